// File: rtl/homo_frame_scheduler_if.sv
// Stream bundle between the channel sources, the scheduler, the homomorphic
// datapath and the per-channel result sinks.
// slave  : scheduler view.
// master : surrounding system view (sources, datapath, sinks).
interface homo_frame_scheduler_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] s0_axis_data_tdata;
  logic             s0_axis_data_tvalid;
  logic             s0_axis_data_tready;
  logic [WIDTH-1:0] s1_axis_data_tdata;
  logic             s1_axis_data_tvalid;
  logic             s1_axis_data_tready;
  logic [WIDTH-1:0] m_axis_data_tdata;
  logic             m_axis_data_tvalid;
  logic             m_axis_data_tready;
  logic [WIDTH-1:0] r_axis_data_tdata;
  logic             r_axis_data_tvalid;
  logic [WIDTH-1:0] m0_axis_data_tdata;
  logic             m0_axis_data_tvalid;
  logic [WIDTH-1:0] m1_axis_data_tdata;
  logic             m1_axis_data_tvalid;

  modport slave (
    input  s0_axis_data_tdata, s0_axis_data_tvalid,
    output s0_axis_data_tready,
    input  s1_axis_data_tdata, s1_axis_data_tvalid,
    output s1_axis_data_tready,
    output m_axis_data_tdata, m_axis_data_tvalid,
    input  m_axis_data_tready,
    input  r_axis_data_tdata, r_axis_data_tvalid,
    output m0_axis_data_tdata, m0_axis_data_tvalid,
    output m1_axis_data_tdata, m1_axis_data_tvalid
  );

  modport master (
    output s0_axis_data_tdata, s0_axis_data_tvalid,
    input  s0_axis_data_tready,
    output s1_axis_data_tdata, s1_axis_data_tvalid,
    input  s1_axis_data_tready,
    input  m_axis_data_tdata, m_axis_data_tvalid,
    output m_axis_data_tready,
    output r_axis_data_tdata, r_axis_data_tvalid,
    input  m0_axis_data_tdata, m0_axis_data_tvalid,
    input  m1_axis_data_tdata, m1_axis_data_tvalid
  );
endinterface

// File: rtl/homo_frame_scheduler.sv
// Frame-granular round-robin time-sharing of one homomorphic envelogram
// datapath between two sample channels. The input side grants whole frames
// and passes samples straight through; a small tag FIFO remembers which
// channel owns each in-flight frame so decimated results can be routed back.
module homo_frame_scheduler #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 1024,
  parameter int DECIM     = 2,
  parameter int TAG_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  homo_frame_scheduler_if.slave bus,
  output logic                  frame_start,
  output logic                  grant_ch,
  output logic                  busy,
  output logic                  orphan_err
);
  localparam int OUT_LEN = FRAME_LEN / DECIM;
  localparam int ICW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int OCW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int AW      = $clog2(TAG_DEPTH);
  localparam logic [ICW-1:0] LAST_IN  = ICW'(FRAME_LEN - 1);
  localparam logic [OCW-1:0] LAST_OUT = OCW'(OUT_LEN - 1);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(TAG_DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state;
  logic                 prio;
  logic [ICW-1:0]       in_cnt;
  logic [OCW-1:0]       out_cnt;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          tag_cnt;

  logic tag_empty, tag_full, pop, push, pick, hs;

  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == FULL_CNT);
  // Last result beat of the head frame retires its tag.
  assign pop  = bus.r_axis_data_tvalid && !tag_empty && (out_cnt == LAST_OUT);
  // Priority channel wins a tie, otherwise the sole requester.
  assign pick = prio ? bus.s1_axis_data_tvalid : !bus.s0_axis_data_tvalid;
  // A slot freed by a same-cycle pop may be reused immediately.
  assign push = (state == IDLE) &&
                (bus.s0_axis_data_tvalid || bus.s1_axis_data_tvalid) &&
                (!tag_full || pop);
  assign busy = (state == STREAM);
  assign hs   = bus.m_axis_data_tvalid && bus.m_axis_data_tready;

  // Zero-latency pass-through of the granted source; everything idle otherwise.
  always_comb begin
    bus.m_axis_data_tvalid  = 1'b0;
    bus.m_axis_data_tdata   = '0;
    bus.s0_axis_data_tready = 1'b0;
    bus.s1_axis_data_tready = 1'b0;
    if (state == STREAM) begin
      if (grant_ch) begin
        bus.m_axis_data_tvalid  = bus.s1_axis_data_tvalid;
        bus.m_axis_data_tdata   = bus.s1_axis_data_tdata;
        bus.s1_axis_data_tready = bus.m_axis_data_tready;
      end else begin
        bus.m_axis_data_tvalid  = bus.s0_axis_data_tvalid;
        bus.m_axis_data_tdata   = bus.s0_axis_data_tdata;
        bus.s0_axis_data_tready = bus.m_axis_data_tready;
      end
    end
  end

  // Input-side FSM: grant a frame, count its handshakes, hand priority over.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      prio        <= 1'b0;
      grant_ch    <= 1'b0;
      frame_start <= 1'b0;
      in_cnt      <= '0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: if (push) begin
          grant_ch    <= pick;
          frame_start <= 1'b1;
          in_cnt      <= '0;
          state       <= STREAM;
        end
        STREAM: if (hs) begin
          if (in_cnt == LAST_IN) begin
            prio   <= ~grant_ch;
            in_cnt <= '0;
            state  <= IDLE;
          end else begin
            in_cnt <= in_cnt + ICW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO of channel IDs for frames granted but not yet fully returned.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= pick;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + (AW+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Output side: register each result beat toward the head frame's owner.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      bus.m0_axis_data_tdata  <= '0;
      bus.m0_axis_data_tvalid <= 1'b0;
      bus.m1_axis_data_tdata  <= '0;
      bus.m1_axis_data_tvalid <= 1'b0;
      out_cnt                 <= '0;
      orphan_err              <= 1'b0;
    end else begin
      bus.m0_axis_data_tvalid <= 1'b0;
      bus.m1_axis_data_tvalid <= 1'b0;
      if (bus.r_axis_data_tvalid) begin
        if (tag_empty) begin
          orphan_err <= 1'b1;
        end else begin
          if (tag_mem[rd_ptr]) begin
            bus.m1_axis_data_tdata  <= bus.r_axis_data_tdata;
            bus.m1_axis_data_tvalid <= 1'b1;
          end else begin
            bus.m0_axis_data_tdata  <= bus.r_axis_data_tdata;
            bus.m0_axis_data_tvalid <= 1'b1;
          end
          out_cnt <= (out_cnt == LAST_OUT) ? '0 : out_cnt + OCW'(1);
        end
      end
    end
  end
endmodule

// File: doc/homo_frame_scheduler.md
Name: homo_frame_scheduler

Overview:
- Time-shares one homomorphic-envelogram datapath (log -> Butterworth LP -> exp -> normalization -> polyphase decimator) between two phonocardiogram sample channels.
- Grants the datapath frame by frame, in round-robin order, and passes samples through to the datapath input stream.
- Tags each granted frame with its channel ID and routes the decimated datapath outputs back to the owning channel.
- Sits between the two channel sources and the homomorphic chain.

Parameters:
- WIDTH, 32, sample width in bits (signed Q3.12 carried in 32 bits).
- FRAME_LEN, 1024, input samples per granted frame.
- DECIM, 2, datapath decimation factor. FRAME_LEN mod DECIM must be 0. Outputs per frame OUT_LEN = FRAME_LEN/DECIM.
- TAG_DEPTH, 4, depth of the in-flight frame tag FIFO (power of 2, minimum 2).

Ports:
- aclk  in  1  clock
- areset  in  1  asynchronous reset, active-high
- s0_axis_data_tdata  in  WIDTH  channel 0 samples
- s0_axis_data_tvalid  in  1  channel 0 valid
- s0_axis_data_tready  out  1  channel 0 ready
- s1_axis_data_tdata  in  WIDTH  channel 1 samples
- s1_axis_data_tvalid  in  1  channel 1 valid
- s1_axis_data_tready  out  1  channel 1 ready
- m_axis_data_tdata  out  WIDTH  to datapath input
- m_axis_data_tvalid  out  1  to datapath input
- m_axis_data_tready  in  1  from datapath input
- r_axis_data_tdata  in  WIDTH  datapath (decimator) output; no backpressure
- r_axis_data_tvalid  in  1  datapath output valid
- m0_axis_data_tdata  out  WIDTH  channel 0 results
- m0_axis_data_tvalid  out  1  channel 0 result valid
- m1_axis_data_tdata  out  WIDTH  channel 1 results
- m1_axis_data_tvalid  out  1  channel 1 result valid
- frame_start  out  1  one-cycle pulse when a frame is granted
- grant_ch  out  1  channel currently owning the input side
- busy  out  1  high while state is STREAM
- orphan_err  out  1  sticky: a result arrived with no tag pending

Behaviour:
- Reset values: all outputs 0. State IDLE, priority pointer = 0, counters cleared, tag FIFO empty, orphan_err cleared.
- Reset takes effect immediately, including mid-frame. The datapath must be reset by the same signal.

Input side FSM:
- IDLE:
  - Request = sX_tvalid of a channel.
  - If tag FIFO is not full and at least one request exists, grant in round-robin order. Priority channel wins on a tie; otherwise the sole requester wins.
  - On grant: push channel ID into the tag FIFO, set grant_ch, pulse frame_start for 1 cycle, clear in_cnt, go to STREAM.
  - If the FIFO is full, stay in IDLE (no grant).
- STREAM:
  - Combinational pass-through, zero latency: m_tdata/m_tvalid = granted sX; granted sX_tready = m_tready; non-granted tready = 0.
  - Count handshakes (valid & ready) in in_cnt.
  - On the handshake with in_cnt == FRAME_LEN-1: set priority to the other channel, return to IDLE.
- Frames are never preempted. A stalled source holds the grant indefinitely.
- In IDLE, m_tvalid = 0 and both s_tready = 0.

Output side (runs concurrently with the input side):
- Each cycle r_tvalid = 1: route r_tdata to the channel at the FIFO head, registered.
  - mX_tdata and mX_tvalid are asserted exactly 1 cycle later; the other channel's valid stays 0.
  - mX_tvalid is a 1-cycle pulse per beat. There is no tready; sinks must accept.
- Count beats in out_cnt. On the beat with out_cnt == OUT_LEN-1: pop the FIFO head and clear out_cnt.
- A push (grant) and a pop in the same cycle are both honoured; occupancy is unchanged.
- If r_tvalid arrives while the FIFO is empty: drop the beat, set orphan_err (cleared only by reset), produce no mX_tvalid.
- in_cnt width: clog2(FRAME_LEN). out_cnt width: clog2(OUT_LEN), minimum 1.

Test Plan:
- Reset then s0 only valid continuously, FRAME_LEN=8, DECIM=2, datapath model = identity with decimate-by-2:
  - frame_start pulses once, grant_ch=0, busy high for exactly 8 transfers.
  - m0 gets 4 pulses, each 1 cycle after its r beat; m1 silent.
- Both s0/s1 valid continuously:
  - grants alternate 0,1,0,1 starting with 0.
  - each mX receives 4 results per frame, in frame order.
- m_axis_data_tready toggling 1/0 during a frame:
  - in_cnt advances only on handshakes.
  - frame still ends after exactly 8 handshakes; no sX sample lost or duplicated.
- TAG_DEPTH=2, datapath withholds results:
  - after 2 grants, the scheduler stays IDLE with s0/s1 tready=0.
  - releasing 4 results permits the third grant in the pop cycle.
- r_tvalid pulse with the FIFO empty after reset:
  - orphan_err=1 and stays set, no mX_tvalid.
- areset asserted at in_cnt=5:
  - all outputs 0 immediately, FIFO empty.
  - after release the next grant goes to channel 0 with in_cnt starting from 0.
